// File: rtl/shift_pkg.sv
// Shared widths, operation encodings and FSM state type for the sequential right shifter.
package shift_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  localparam logic [1:0] OP_ROR = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_SRF = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/rshift_stage.sv
// One binary-weighted right-shift stage; amount is one-hot (1/2/4/8).
module rshift_stage
  import shift_pkg::*;
(
  input  logic [WIDTH-1:0] data_i,
  input  logic [CNT_W-1:0] amount_i,
  input  logic             enable_i,
  input  logic [1:0]       op_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] data_o
);

  logic ror;
  assign ror = (op_i == OP_ROR);

  always_comb begin
    data_o = data_i;
    if (enable_i) begin
      // Rotate feeds the shifted-out LSBs back in; every other op uses the resolved fill bit.
      case (amount_i)
        4'd1:    data_o = {(ror ? data_i[0]   : fill_i),       data_i[15:1]};
        4'd2:    data_o = {(ror ? data_i[1:0] : {2{fill_i}}),  data_i[15:2]};
        4'd4:    data_o = {(ror ? data_i[3:0] : {4{fill_i}}),  data_i[15:4]};
        4'd8:    data_o = {(ror ? data_i[7:0] : {8{fill_i}}),  data_i[15:8]};
        default: data_o = data_i;
      endcase
    end
  end

endmodule

// File: rtl/shift_right_seq.sv
// Sequential right shift/rotate: four stages of 1/2/4/8 applied over four SHIFT cycles.
// state | meaning
// IDLE  | waiting for Start
// SHIFT | applying stage k = 0..3 to the working register
// DONE  | Out valid for one cycle; Start here chains the next operation
module shift_right_seq
  import shift_pkg::*;
#(
  parameter int WIDTH_P = WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Start,
  input  logic [WIDTH_P-1:0] In,
  input  logic [CNT_W-1:0]   Cnt,
  input  logic [1:0]         Op,
  input  logic               Fill_bit,
  output logic [WIDTH_P-1:0] Out,
  output logic               Busy,
  output logic               Done
);

  state_e           state_q, state_d;
  logic [1:0]       k_q, k_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             fill_q, fill_d;
  logic [WIDTH-1:0] stage_out;
  logic [CNT_W-1:0] stage_amt;

  assign stage_amt = 4'b0001 << k_q;

  rshift_stage u_stage (
    .data_i   (work_q),
    .amount_i (stage_amt),
    .enable_i (cnt_q[k_q]),
    .op_i     (op_q),
    .fill_i   (fill_q),
    .data_o   (stage_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= 2'd0;
      work_q  <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      op_q    <= 2'b00;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      work_q  <= work_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      fill_q  <= fill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    work_d  = work_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    fill_d  = fill_q;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          state_d = SHIFT;
          k_d     = 2'd0;
          work_d  = In;
          cnt_d   = Cnt;
          op_d    = Op;
          // Resolve the fill once at capture so the stage only sees a single bit.
          fill_d  = (Op == OP_SRA) ? In[WIDTH-1] :
                    (Op == OP_SRF) ? Fill_bit : 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        work_d = stage_out;
        if (k_q == 2'd3) begin
          state_d = DONE;
          out_d   = stage_out;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Out  = out_q;
  assign Busy = (state_q == SHIFT);
  assign Done = (state_q == DONE);

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed self-checking bench for shift_right_seq: latency, fills, holds, chaining and reset abort.
module tb_shift_right_seq;

  logic        clk;
  logic        rst;
  logic        Start;
  logic [15:0] In;
  logic [3:0]  Cnt;
  logic [1:0]  Op;
  logic        Fill_bit;
  logic [15:0] Out;
  logic        Busy;
  logic        Done;

  int checks   = 0;
  int failures = 0;
  logic [15:0] prev_out = 16'h0000;

  shift_right_seq dut (
    .clk      (clk),
    .rst      (rst),
    .Start    (Start),
    .In       (In),
    .Cnt      (Cnt),
    .Op       (Op),
    .Fill_bit (Fill_bit),
    .Out      (Out),
    .Busy     (Busy),
    .Done     (Done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic run_op(input string name, input logic [15:0] din, input logic [3:0] cnt,
                        input logic [1:0] op, input logic fill, input logic [15:0] expv,
                        input bit mid_pulse);
    int n;
    @(negedge clk);
    Start = 1'b1; In = din; Cnt = cnt; Op = op; Fill_bit = fill;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0; In = ~din; Cnt = ~cnt; Op = ~op; Fill_bit = ~fill;
    n = 0;
    while (Done !== 1'b1 && n < 10) begin
      checks++;
      if (Busy !== 1'b1) begin
        failures++;
        $display("FAIL %s busy n=%0d: got %b expected 1", name, n, Busy);
      end
      checks++;
      if (Out !== prev_out) begin
        failures++;
        $display("FAIL %s out_hold n=%0d: got %h expected %h", name, n, Out, prev_out);
      end
      if (mid_pulse && n == 1) Start = 1'b1;
      if (mid_pulse && n == 2) Start = 1'b0;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 4) begin
      failures++;
      $display("FAIL %s latency: got %0d expected 4", name, n);
    end
    checks++;
    if (Out !== expv) begin
      failures++;
      $display("FAIL %s result: got %h expected %h", name, Out, expv);
    end
    checks++;
    if (Busy !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_in_done: got %b expected 0", name, Busy);
    end
    @(negedge clk);
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL %s after_done: got done=%b busy=%b expected 0 0", name, Done, Busy);
    end
    prev_out = expv;
  endtask

  task automatic test_reset();
    rst = 1'b1; Start = 1'b0; In = 16'hFFFF; Cnt = 4'hF; Op = 2'b00; Fill_bit = 1'b1;
    #2;
    checks++;
    if (Out !== 16'h0000 || Busy !== 1'b0 || Done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got out=%h busy=%b done=%b expected 0000 0 0", Out, Busy, Done);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    prev_out = 16'h0000;
  endtask

  task automatic test_ror();
    run_op("ror_8001_4", 16'h8001, 4'd4, 2'b00, 1'b0, 16'h1800, 1'b0);
    run_op("ror_0001_15", 16'h0001, 4'd15, 2'b00, 1'b0, 16'h0002, 1'b0);
    run_op("ror_1234_9", 16'h1234, 4'd9, 2'b00, 1'b0, 16'h1A09, 1'b0);
  endtask

  task automatic test_shift_edges();
    run_op("sra_8000_15", 16'h8000, 4'd15, 2'b10, 1'b0, 16'hFFFF, 1'b0);
    run_op("srl_8000_15", 16'h8000, 4'd15, 2'b01, 1'b0, 16'h0001, 1'b0);
    run_op("sra_7fff_15", 16'h7FFF, 4'd15, 2'b10, 1'b1, 16'h0000, 1'b0);
    run_op("sra_8421_6", 16'h8421, 4'd6, 2'b10, 1'b0, 16'hFE10, 1'b0);
  endtask

  task automatic test_fill();
    run_op("srf_0000_3_f1", 16'h0000, 4'd3, 2'b11, 1'b1, 16'hE000, 1'b0);
    run_op("srf_ffff_5_f0", 16'hFFFF, 4'd5, 2'b11, 1'b0, 16'h07FF, 1'b0);
  endtask

  task automatic test_cnt_zero();
    run_op("cnt0_ror", 16'hA5C3, 4'd0, 2'b00, 1'b1, 16'hA5C3, 1'b1);
    run_op("cnt0_srl", 16'hA5C3, 4'd0, 2'b01, 1'b1, 16'hA5C3, 1'b0);
    run_op("cnt0_sra", 16'hA5C3, 4'd0, 2'b10, 1'b0, 16'hA5C3, 1'b1);
    run_op("cnt0_srf", 16'hA5C3, 4'd0, 2'b11, 1'b1, 16'hA5C3, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_out;
    logic        exp_done, exp_busy;
    @(negedge clk);
    Start = 1'b1; In = 16'hF00F; Cnt = 4'd8; Op = 2'b01; Fill_bit = 1'b1;
    @(posedge clk);
    @(negedge clk);
    In = 16'h00F0; Cnt = 4'd4; Op = 2'b00; Fill_bit = 1'b0;
    for (int n = 0; n <= 10; n++) begin
      exp_done = (n == 4) || (n == 9);
      exp_busy = (n < 4) || (n >= 5 && n < 9);
      exp_out  = (n < 4) ? prev_out : (n < 9) ? 16'h00F0 : 16'h000F;
      checks++;
      if (Done !== exp_done || Busy !== exp_busy || Out !== exp_out) begin
        failures++;
        $display("FAIL b2b n=%0d: got done=%b busy=%b out=%h expected %b %b %h",
                 n, Done, Busy, Out, exp_done, exp_busy, exp_out);
      end
      if (n == 5) Start = 1'b0;
      @(negedge clk);
    end
    prev_out = 16'h000F;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    Start = 1'b1; In = 16'h1234; Cnt = 4'd5; Op = 2'b01; Fill_bit = 1'b0;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (Out !== 16'h0000 || Busy !== 1'b0 || Done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_async: got out=%h busy=%b done=%b expected 0000 0 0", Out, Busy, Done);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    prev_out = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (Done !== 1'b0 || Busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_quiet i=%0d: got done=%b busy=%b expected 0 0", i, Done, Busy);
      end
    end
    run_op("after_reset_ror", 16'h00FF, 4'd8, 2'b00, 1'b0, 16'hFF00, 1'b0);
  endtask

  initial begin
    test_reset();
    test_ror();
    test_shift_edges();
    test_fill();
    test_cnt_zero();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_right_seq.md
SHIFT_RIGHT_SEQ -- requirements
Module: shift_right_seq

Interface
REQ-001 Parameter: WIDTH, default 16, data width; only 16 is supported, and Cnt is fixed at 4 bits.
REQ-002 The port list SHALL be as follows, with clock and reset first:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- Start  in  1  request strobe; sampled on each rising edge.
- In  in  16  operand to shift.
- Cnt  in  4  shift/rotate amount, 0..15.
- Op  in  2  operation select: 00 rotate right (ROR), 01 logical shift right (SRL), 10 arithmetic shift right (SRA), 11 shift right with Fill_bit fill (SRF).
- Fill_bit  in  1  fill value for SRF.
- Out  out  16  registered result.
- Busy  out  1  high while an operation is in flight.
- Done  out  1  one-cycle pulse marking Out valid.

Function
REQ-003 The FSM SHALL have three states, with these transitions:
- IDLE -> SHIFT on Start.
- SHIFT stays for 4 cycles, stage index k = 0..3, then -> DONE.
- DONE -> IDLE after 1 cycle, or -> SHIFT if Start is high in DONE.
REQ-004 Start SHALL be accepted only in IDLE or DONE; when accepted, In, Cnt, Op and Fill_bit are captured into internal registers and k is cleared to 0.
REQ-005 Start SHALL be ignored while in SHIFT; captured operands are unaffected by input changes after capture.
REQ-006 In SHIFT stage k, the working register SHALL be shifted right by 2^k if captured Cnt[k]=1, and left unchanged otherwise.
REQ-007 Vacated MSBs SHALL be filled as follows:
- ROR: the bits shifted out of the LSB end.
- SRL: 0.
- SRA: captured In[15].
- SRF: captured Fill_bit.
REQ-008 Latency: with Start sampled at edge E0, Done SHALL be high and Out valid in the cycle after edge E4 (4 cycles).
REQ-009 Out SHALL update only on entry to DONE and hold its value otherwise, including through later SHIFT cycles until the next DONE.
REQ-010 Busy SHALL be 1 exactly in SHIFT; Done SHALL be 1 exactly in DONE; the two are never high together.
REQ-011 Cnt=0 SHALL still take the full latency and yield Out=In for every Op.
REQ-012 ROR SHALL be modulo 16; SRL/SRA/SRF by 15 leave only the original In[15] in bit 0, with fill in bits 15:1.
REQ-013 Back-to-back operation: Start asserted during DONE begins the next operation with no IDLE cycle, and Done pulses once per operation.

Reset
REQ-014 While rst=1, asynchronously: state=IDLE, k=0, working and capture registers=0, Out=16'h0000, Busy=0, Done=0.
REQ-015 Reset during SHIFT or DONE SHALL abort the operation with no Done pulse; the first edge after rst deasserts behaves as IDLE.

Structure
REQ-016 A shared package shift_pkg SHALL hold:
- WIDTH=16 and CNT_W=4.
- Op encodings OP_ROR, OP_SRL, OP_SRA, OP_SRF.
- The state enum {IDLE, SHIFT, DONE}.
REQ-017 One combinational sub-module, rshift_stage, SHALL be used.
- Inputs: data, amount 2^k (1/2/4/8), enable, Op, fill bit.
- Output: shifted data.
- Reused each SHIFT cycle with a muxed amount.

Verification
REQ-018 ROR: In=16'h8001, Cnt=4, Op=00 -> Out=16'h1800, Done high exactly 4 cycles after Start, Busy high for 4 cycles.
REQ-019 SRA: In=16'h8000, Cnt=15, Op=10 -> Out=16'hFFFF; SRL with the same inputs (Op=01) -> Out=16'h0001.
REQ-020 SRF: In=16'h0000, Cnt=3, Op=11, Fill_bit=1 -> Out=16'hE000; Fill_bit changed after Start has no effect.
REQ-021 Cnt=0: In=16'hA5C3, each Op -> Out=16'hA5C3 after 4 cycles; Start pulsed during SHIFT -> ignored, single Done.
REQ-022 Back-to-back: Start held high across two operations (16'hF00F SRL 8, then 16'h00F0 ROR 4) -> Out=16'h00F0, then Out=16'h000F, Done pulses 5 cycles apart.
REQ-023 Reset: assert rst at stage k=2 -> immediately Out=0, Busy=0, Done=0; no Done pulse after release; next Start completes normally.
